// File: rtl/sha256_transform_core.sv
// SHA-256 compression pipeline of NUM_ROUNDS/LOOP stages. Each stage folds LOOP
// rounds by recirculating its own registers while feedback is high.
module sha256_transform_core #(
    parameter int LOOP          = 1,
    parameter int NUM_ROUNDS    = 64,
    parameter int CONST_W_FLAGS = 65535
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         feedback,
    input  logic [5:0]   cnt,
    input  logic [255:0] rx_state,
    input  logic [511:0] rx_input,
    output logic [255:0] tx_hash
);
    localparam int STAGES = NUM_ROUNDS / LOOP;

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Parameter legality; CONST_W_FLAGS is only a hint and never alters the datapath.
    if (LOOP < 1 || LOOP > 32 || (LOOP & (LOOP - 1)) != 0) begin : g_bad_loop
        $error("LOOP must be a power of 2 in 1..32");
    end
    if (NUM_ROUNDS < 1 || NUM_ROUNDS > 64 || (NUM_ROUNDS % LOOP) != 0) begin : g_bad_rounds
        $error("NUM_ROUNDS must be 1..64 and a multiple of LOOP");
    end
    if (CONST_W_FLAGS < 0 || CONST_W_FLAGS > 65535) begin : g_bad_flags
        $error("CONST_W_FLAGS must fit in 16 bits");
    end

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // One round on a packed {h,g,f,e,d,c,b,a} working state.
    function automatic logic [255:0] round_f(input logic [255:0] s,
                                             input logic [31:0]  k,
                                             input logic [31:0]  w);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {h, g, f, e, d, c, b, a} = s;
        t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        return {g, f, e, d + t1, c, b, a, t1 + t2};
    endfunction

    // Window holds W[t..t+15] with W[t] in the low word; slide by one and append W[t+16].
    function automatic logic [511:0] sched_f(input logic [511:0] win);
        logic [31:0] s0, s1, w16;
        s0  = rotr(win[63:32], 7) ^ rotr(win[63:32], 18) ^ (win[63:32] >> 3);
        s1  = rotr(win[479:448], 17) ^ rotr(win[479:448], 19) ^ (win[479:448] >> 10);
        w16 = s1 + win[319:288] + s0 + win[31:0];
        return {w16, win[511:32]};
    endfunction

    // No handshake: the caller pulses feedback low exactly when cnt==0 and steps
    // cnt through 0..LOOP-1; with LOOP=1 every edge is a load edge.
    logic       fb;
    logic [5:0] cnt_m;
    assign fb    = (LOOP > 1) && feedback;
    assign cnt_m = cnt & 6'(LOOP - 1);

    logic [255:0] stage_state [STAGES];
    logic [511:0] stage_w     [STAGES];

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic [255:0] src_state;
        logic [255:0] state_q;
        logic [511:0] src_w;
        logic [511:0] w_q;
        logic [5:0]   k_idx;

        if (s == 0) begin : g_first
            assign src_state = fb ? state_q : rx_state;
            assign src_w     = fb ? w_q     : rx_input;
        end else begin : g_next
            assign src_state = fb ? state_q : stage_state[s-1];
            assign src_w     = fb ? w_q     : stage_w[s-1];
        end

        assign k_idx = 6'(s * LOOP) + (fb ? cnt_m : 6'd0);

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                state_q <= '0;
                w_q     <= '0;
            end else begin
                state_q <= round_f(src_state, K_TAB[k_idx], src_w[31:0]);
                w_q     <= sched_f(src_w);
            end
        end

        assign stage_state[s] = state_q;
        assign stage_w[s]     = w_q;
    end

    logic [255:0] last_state;
    logic [255:0] out_d;
    assign last_state = stage_state[STAGES-1];

    // Full compression adds the chaining state back; truncated runs expose raw a..h.
    if (NUM_ROUNDS == 64) begin : g_feed_forward
        for (genvar i = 0; i < 8; i++) begin : g_word
            assign out_d[32*i +: 32] = rx_state[32*i +: 32] + last_state[32*i +: 32];
        end
    end else begin : g_raw
        assign out_d = last_state;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_hash <= '0;
        end else if (!fb) begin
            tx_hash <= out_d;
        end
    end
endmodule

// File: tb/tb_sha256_transform_core.sv
// Bench for sha256_transform_core: three configurations share stimulus and are
// scored against a textbook SHA-256 model plus known FIPS digests.
`timescale 1ns/1ps
module tb_sha256_transform_core;
    localparam logic [255:0] IV = 256'h5be0cd19_1f83d9ab_9b05688c_510e527f_a54ff53a_3c6ef372_bb67ae85_6a09e667;
    localparam logic [511:0] ABC_BLK   = {32'h00000018, 448'd0, 32'h61626380};
    localparam logic [511:0] EMPTY_BLK = {480'd0, 32'h80000000};
    localparam logic [255:0] ABC_DIGEST   = 256'hf20015ad_b410ff61_96177a9c_b00361a3_5dae2223_414140de_8f01cfea_ba7816bf;
    localparam logic [255:0] EMPTY_DIGEST = 256'h7852b855_a495991b_649b934c_27ae41e4_996fb924_9afbf4c8_98fc1c14_e3b0c442;
    localparam int TAG_RAND  = 0;
    localparam int TAG_ABC   = 1;
    localparam int TAG_EMPTY = 2;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef struct {
        int           due;
        logic [255:0] exp;
        int           tag;
    } exp_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n = 1'b0;
    logic         fb4     = 1'b0;
    logic [5:0]   cnt4    = 6'd0;
    logic [255:0] rx_state = IV;
    logic [511:0] rx_input = '0;
    logic [255:0] hash64, hash61, hash4;

    int cyc = 0;
    logic rst_at_edge = 1'b0;
    logic fb4_at_edge = 1'b0;
    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= reset_n;
        fb4_at_edge <= fb4;
    end

    sha256_transform_core #(.LOOP(1), .NUM_ROUNDS(64)) dut64 (
        .clk(clk), .reset_n(reset_n), .feedback(1'b0), .cnt(6'd0),
        .rx_state(rx_state), .rx_input(rx_input), .tx_hash(hash64));
    sha256_transform_core #(.LOOP(1), .NUM_ROUNDS(61)) dut61 (
        .clk(clk), .reset_n(reset_n), .feedback(1'b0), .cnt(6'd0),
        .rx_state(rx_state), .rx_input(rx_input), .tx_hash(hash61));
    sha256_transform_core #(.LOOP(4), .NUM_ROUNDS(64)) dut4 (
        .clk(clk), .reset_n(reset_n), .feedback(fb4), .cnt(cnt4),
        .rx_state(rx_state), .rx_input(rx_input), .tx_hash(hash4));

    // ---------------- reference model ----------------
    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] ref_hash(input logic [255:0] iv, input logic [511:0] blk, input int nr);
        logic [31:0]  w [64];
        logic [31:0]  v [8];
        logic [31:0]  t1, t2, s0, s1;
        logic [255:0] r;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) begin
                w[t] = blk[32*t +: 32];
            end else begin
                s0   = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
                s1   = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
                w[t] = s1 + w[t-7] + s0 + w[t-16];
            end
        end
        for (int i = 0; i < 8; i++) v[i] = iv[32*i +: 32];
        for (int t = 0; t < nr; t++) begin
            t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
                 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[t];
            t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
                 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[32*i +: 32] = (nr == 64) ? iv[32*i +: 32] + v[i] : v[i];
        return r;
    endfunction

    function automatic logic [511:0] rand_blk();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom();
        return b;
    endfunction

    function automatic logic [255:0] rand_state();
        logic [255:0] s;
        for (int i = 0; i < 8; i++) s[32*i +: 32] = $urandom();
        return s;
    endfunction

    // ---------------- scoreboard ----------------
    exp_t q64[$];
    exp_t q61[$];
    exp_t q4[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   ph4      = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic [511:0] blk, input int tag, input bit push);
        exp_t e;
        @(negedge clk);
        rx_input = blk;
        cnt4     = 6'(ph4);
        fb4      = (ph4 != 0);
        if (push) begin
            e.tag = tag;
            e.due = cyc + 65;
            e.exp = ref_hash(rx_state, blk, 64);
            q64.push_back(e);
            if (ph4 == 0) q4.push_back(e);
            e.due = cyc + 62;
            e.exp = ref_hash(rx_state, blk, 61);
            q61.push_back(e);
        end
        ph4 = (ph4 + 1) % 4;
    endtask

    task automatic do_reset(input int n, input logic [255:0] new_state);
        @(negedge clk);
        reset_n  = 1'b0;
        fb4      = 1'b0;
        cnt4     = 6'd0;
        ph4      = 0;
        rx_state = new_state;
        q64.delete();
        q61.delete();
        q4.delete();
        repeat (n) @(negedge clk);
        check("dut64 reset", hash64, '0);
        check("dut61 reset", hash61, '0);
        check("dut4 reset", hash4, '0);
        reset_n = 1'b1;
    endtask

    task automatic drain();
        int budget;
        int left;
        budget = 200;
        while ((q64.size() + q61.size() + q4.size()) > 0 && budget > 0) begin
            step(rand_blk(), TAG_RAND, 1'b0);
            budget--;
        end
        left = q64.size() + q61.size() + q4.size();
        n_checks++;
        if (left != 0) begin
            n_fail++;
            $display("FAIL drain timeout: %0d expected outputs never seen, required 0", left);
        end
    endtask

    // ---------------- monitor ----------------
    logic [255:0] last_exp4 = '0;
    bit           hold4_ok  = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_at_edge) begin
            hold4_ok = 1'b0;
        end else begin
            if (q64.size() != 0 && q64[0].due == cyc) begin
                e = q64.pop_front();
                check("dut64 digest", hash64, e.exp);
                if (e.tag == TAG_ABC)   check("dut64 abc vector", hash64, ABC_DIGEST);
                if (e.tag == TAG_EMPTY) check("dut64 empty vector", hash64, EMPTY_DIGEST);
            end
            if (q61.size() != 0 && q61[0].due == cyc) begin
                e = q61.pop_front();
                check("dut61 state", hash61, e.exp);
                if (e.tag == TAG_ABC)
                    check("dut61 abc e-word", {224'd0, hash61[159:128]}, {224'd0, 32'h961f4894});
            end
            if (!fb4_at_edge) begin
                if (q4.size() != 0 && q4[0].due == cyc) begin
                    e = q4.pop_front();
                    check("dut4 digest", hash4, e.exp);
                    if (e.tag == TAG_ABC) check("dut4 abc vector", hash4, ABC_DIGEST);
                    last_exp4 = e.exp;
                    hold4_ok  = 1'b1;
                end else begin
                    hold4_ok = 1'b0;
                end
            end else if (hold4_ok) begin
                check("dut4 hold on feedback edge", hash4, last_exp4);
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        do_reset(2, IV);

        step(ABC_BLK, TAG_ABC, 1'b1);
        step(EMPTY_BLK, TAG_EMPTY, 1'b1);
        repeat (30) step(rand_blk(), TAG_RAND, 1'b1);
        drain();

        repeat (20) step(rand_blk(), TAG_RAND, 1'b1);
        do_reset(1, IV);
        step(ABC_BLK, TAG_ABC, 1'b1);
        repeat (25) step(rand_blk(), TAG_RAND, 1'b1);
        drain();

        do_reset(1, rand_state());
        repeat (40) step(rand_blk(), TAG_RAND, 1'b1);
        step(ABC_BLK, TAG_RAND, 1'b1);
        step(EMPTY_BLK, TAG_RAND, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
